// File: rtl/mux16_scan_ctrl.sv
// Serialiser front end for a 16:1 mux tree: latches a word, then walks the
// 4-bit select across all 16 positions with per-bit and end-of-frame strobes.
module mux16_scan_ctrl #(
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        abort,
  output logic [15:0] w,
  output logic [3:0]  s,
  output logic        bit_valid,
  output logic        frame_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] START  = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] END    = MSB_FIRST ? 4'd0  : 4'd15;
  localparam bit         NO_GAP = (GAP == 0);

  state_t     state;
  logic [3:0] gap_cnt;
  logic [3:0] s_next;
  logic       at_end;
  logic       accept;

  always_comb begin
    s_next = MSB_FIRST ? (s - 4'd1) : (s + 4'd1);
  end

  assign at_end = (s == END);

  // Reload at the final bit is only offered without a gap, giving bubble-free streaming.
  assign load_ready = !abort &&
                      ((state == ST_IDLE) || ((state == ST_SCAN) && at_end && NO_GAP));
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      w          <= 16'h0000;
      s          <= 4'h0;
      gap_cnt    <= 4'h0;
      bit_valid  <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      gap_cnt    <= 4'h0;
      bit_valid  <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_SCAN;
            w          <= load_data;
            s          <= START;
            bit_valid  <= 1'b1;
            frame_last <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!at_end) begin
            s          <= s_next;
            bit_valid  <= 1'b1;
            frame_last <= (s_next == END);
          end else if (accept) begin
            w          <= load_data;
            s          <= START;
            bit_valid  <= 1'b1;
            frame_last <= 1'b0;
          end else if (!NO_GAP) begin
            state      <= ST_GAP;
            gap_cnt    <= 4'(GAP - 1);
            bit_valid  <= 1'b0;
            frame_last <= 1'b0;
          end else begin
            state      <= ST_IDLE;
            bit_valid  <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'h0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          bit_valid  <= 1'b0;
          frame_last <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Directed bench for mux16_scan_ctrl: a cycle-exact expected trace is queued
// as words are offered and compared against the DUT and a model of the mux.
module tb_mux16_scan_ctrl;

  typedef struct {
    bit         v;
    bit         b;
    logic [3:0] s;
    bit         last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        lv   [3];
  logic [15:0] ld   [3];
  logic        ab   [3];
  logic        lr   [3];
  logic [15:0] w    [3];
  logic [3:0]  s    [3];
  logic        bv   [3];
  logic        fl   [3];
  logic        busy [3];

  exp_t sb[$];
  int   cur;
  int   passes;
  int   total;

  // dut0: LSB first, no gap; dut1: MSB first, no gap; dut2: LSB first, gap of 3
  mux16_scan_ctrl #(.GAP(0), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(lr[0]), .abort(ab[0]), .w(w[0]), .s(s[0]),
    .bit_valid(bv[0]), .frame_last(fl[0]), .busy(busy[0]));

  mux16_scan_ctrl #(.GAP(0), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(lr[1]), .abort(ab[1]), .w(w[1]), .s(s[1]),
    .bit_valid(bv[1]), .frame_last(fl[1]), .busy(busy[1]));

  mux16_scan_ctrl #(.GAP(3), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_data(ld[2]),
    .load_ready(lr[2]), .abort(ab[2]), .w(w[2]), .s(s[2]),
    .bit_valid(bv[2]), .frame_last(fl[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int k, input bit v, input logic [15:0] d, input bit a);
    lv[k] = v;
    ld[k] = d;
    ab[k] = a;
  endtask

  task automatic push_bits(input logic [15:0] word, input bit msb, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.v    = 1'b1;
      e.s    = msb ? 4'(15 - i) : 4'(i);
      e.b    = word[e.s];
      e.last = (i == 15);
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.v    = 1'b0;
      e.b    = 1'b0;
      e.s    = 4'h0;
      e.last = 1'b0;
      sb.push_back(e);
    end
  endtask

  // One clock: advance past the edge, then compare the active DUT to the trace
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_output("bit_valid", 32'(bv[cur]), 32'(e.v));
      if (e.v) begin
        check_output("s", 32'(s[cur]), 32'(e.s));
        check_output("f", 32'(w[cur][s[cur]]), 32'(e.b));
        check_output("frame_last", 32'(fl[cur]), 32'(e.last));
      end else begin
        check_output("frame_last_idle", 32'(fl[cur]), 32'(0));
      end
    end else begin
      check_output("bit_valid_idle", 32'(bv[cur]), 32'(0));
      check_output("frame_last_idle", 32'(fl[cur]), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    passes = 0;
    total  = 0;
    cur    = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 3; k++) apply_stimulus(k, 1'b0, 16'h0000, 1'b0);

    // Reset held for three cycles
    repeat (3) cycle();
    check_output("rst_w", 32'(w[0]), 32'h0);
    check_output("rst_s", 32'(s[0]), 32'h0);
    check_output("rst_busy", 32'(busy[0]), 32'h0);
    check_output("rst_load_ready", 32'(lr[0]), 32'h1);
    check_output("rst_s_msb", 32'(s[1]), 32'h0);
    rst_n = 1'b1;
    #1;
    check_output("rel_busy", 32'(busy[0]), 32'h0);
    check_output("rel_load_ready", 32'(lr[0]), 32'h1);

    // LSB-first single frame
    cur = 0;
    apply_stimulus(0, 1'b1, 16'hA5C3, 1'b0);
    push_bits(16'hA5C3, 1'b0, 16);
    cycle();
    apply_stimulus(0, 1'b0, 16'h0000, 1'b0);
    repeat (15) cycle();
    push_idle(1);
    cycle();
    check_output("lsb_end_busy", 32'(busy[0]), 32'h0);
    check_output("lsb_end_ready", 32'(lr[0]), 32'h1);

    // MSB-first back-to-back frames
    cur = 1;
    apply_stimulus(1, 1'b1, 16'hFFFF, 1'b0);
    push_bits(16'hFFFF, 1'b1, 16);
    push_bits(16'h0001, 1'b1, 16);
    cycle();
    apply_stimulus(1, 1'b1, 16'h0001, 1'b0);
    repeat (16) cycle();
    apply_stimulus(1, 1'b0, 16'h0000, 1'b0);
    repeat (15) cycle();
    push_idle(1);
    cycle();
    check_output("msb_end_busy", 32'(busy[1]), 32'h0);

    // Gap spacing with two words queued
    cur = 2;
    apply_stimulus(2, 1'b1, 16'h1234, 1'b0);
    push_bits(16'h1234, 1'b0, 16);
    push_idle(4);
    push_bits(16'hABCD, 1'b0, 16);
    cycle();
    apply_stimulus(2, 1'b1, 16'hABCD, 1'b0);
    repeat (15) cycle();
    cycle();
    check_output("gap_ready", 32'(lr[2]), 32'h0);
    check_output("gap_busy", 32'(busy[2]), 32'h1);
    repeat (3) cycle();
    check_output("gap_idle_ready", 32'(lr[2]), 32'h1);
    check_output("gap_idle_busy", 32'(busy[2]), 32'h0);
    cycle();
    apply_stimulus(2, 1'b0, 16'h0000, 1'b0);
    repeat (15) cycle();
    push_idle(5);
    repeat (5) cycle();
    check_output("gap_end_busy", 32'(busy[2]), 32'h0);

    // Abort at s=6
    cur = 0;
    apply_stimulus(0, 1'b1, 16'h5A5A, 1'b0);
    push_bits(16'h5A5A, 1'b0, 7);
    cycle();
    apply_stimulus(0, 1'b0, 16'h0000, 1'b0);
    repeat (6) cycle();
    apply_stimulus(0, 1'b0, 16'h0000, 1'b1);
    #1;
    check_output("abort_ready", 32'(lr[0]), 32'h0);
    push_idle(1);
    cycle();
    apply_stimulus(0, 1'b0, 16'h0000, 1'b0);
    check_output("abort_s_hold", 32'(s[0]), 32'h6);
    check_output("abort_busy", 32'(busy[0]), 32'h0);

    // Abort coincident with the final-bit reload
    apply_stimulus(0, 1'b1, 16'h1111, 1'b0);
    push_bits(16'h1111, 1'b0, 16);
    cycle();
    apply_stimulus(0, 1'b1, 16'h2222, 1'b0);
    repeat (15) cycle();
    apply_stimulus(0, 1'b1, 16'h2222, 1'b1);
    #1;
    check_output("abort_reload_ready", 32'(lr[0]), 32'h0);
    push_idle(1);
    cycle();
    apply_stimulus(0, 1'b0, 16'h0000, 1'b0);
    check_output("abort_reload_w", 32'(w[0]), 32'h1111);
    check_output("abort_reload_busy", 32'(busy[0]), 32'h0);
    check_output("abort_reload_s", 32'(s[0]), 32'hF);

    // Asynchronous reset mid-frame at s=9
    apply_stimulus(0, 1'b1, 16'hC3C3, 1'b0);
    push_bits(16'hC3C3, 1'b0, 10);
    cycle();
    apply_stimulus(0, 1'b0, 16'h0000, 1'b0);
    repeat (9) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_bit_valid", 32'(bv[0]), 32'h0);
    check_output("async_frame_last", 32'(fl[0]), 32'h0);
    check_output("async_busy", 32'(busy[0]), 32'h0);
    check_output("async_s", 32'(s[0]), 32'h0);
    check_output("async_w", 32'(w[0]), 32'h0);
    repeat (2) cycle();
    rst_n = 1'b1;
    apply_stimulus(0, 1'b1, 16'h0F0F, 1'b0);
    push_bits(16'h0F0F, 1'b0, 16);
    cycle();
    apply_stimulus(0, 1'b0, 16'h0000, 1'b0);
    repeat (15) cycle();
    push_idle(1);
    cycle();
    check_output("post_reset_busy", 32'(busy[0]), 32'h0);

    check_output("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mux16_scan_ctrl.md
# mux16_scan_ctrl

Sequencer that sits directly upstream of the 16:1 multiplexer tree, which uses two 8:1 stages and a 2:1 stage. It accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the 4-bit select through all 16 positions, one per clock, so that the mux output `f` streams the word out serially. Qualifying strobes `bit_valid` and `frame_last` mark each bit and the end of each frame for the downstream consumer.

## Interface
- `GAP`, default 0: idle cycles inserted after each frame before the next load is accepted (0..15).
- `MSB_FIRST`, default 0: 0 steps the select 0→15; 1 steps it 15→0.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load_valid`  in  1  upstream has a word on `load_data`.
- `load_data`  in  16  word to serialise.
- `load_ready`  out  1  block can accept a word this cycle.
- `abort`  in  1  synchronous abandon of the current frame.
- `w`  out  16  registered word, drives the mux data inputs.
- `s`  out  4  registered select, drives the mux select inputs.
- `bit_valid`  out  1  `f` from the downstream mux is a valid data bit this cycle.
- `frame_last`  out  1  current bit is the final bit of the frame.
- `busy`  out  1  state is not IDLE.

## Operation
- There are three states: IDLE, SCAN and GAP. All outputs decode from registers only; there is no input-to-output combinational path except `load_ready`, which depends on `abort`.
- The start position is `START` = 0, or 15 when `MSB_FIRST`=1.
- The end position is `END` = 15, or 0 when `MSB_FIRST`=1.
- Accept condition: `load_valid & load_ready` sampled at a rising edge.
- `load_ready` = !`abort` & ((state==IDLE) | (state==SCAN & `s`==`END` & `GAP`==0)).
- IDLE:
  - `bit_valid`=0.
  - On accept: `w`<=`load_data`, `s`<=`START`, state goes to SCAN.
- SCAN:
  - `bit_valid`=1.
  - `frame_last`=(`s`==`END`).
  - While `s`!=`END`: `s` increments (or decrements when `MSB_FIRST`=1) by 1 each cycle.
  - At `s`==`END`, if accept occurs (only possible when `GAP`=0): reload `w` and set `s`<=`START`; state stays SCAN (back-to-back, no bubble).
  - At `s`==`END` otherwise: state goes to GAP if `GAP`>0, else to IDLE.
- GAP:
  - `bit_valid`=0.
  - A 4-bit counter loads `GAP`-1 on entry and decrements each cycle.
  - When the counter reaches 0, state goes to IDLE.
- `abort`=1 at an edge forces state to IDLE from any state and clears the gap counter.
  - `w` and `s` retain their values.
  - `abort` overrides a simultaneous accept: `load_ready` is 0 while `abort` is high.
- `s` never wraps within a frame. It holds its value in IDLE and GAP.
- `load_data` is ignored unless the accept condition holds.

## Timing
- Reset (`rst_n`=0, takes effect immediately):
  - state=IDLE, `w`=16'h0000, `s`=4'h0, gap counter=0.
  - `bit_valid`=0, `frame_last`=0, `busy`=0.
  - `load_ready`=1 (when `abort`=0).
- Latency: accept at edge k; the first valid bit is presented in the cycle after edge k.
- Frame length: exactly 16 `bit_valid` cycles; `frame_last` is high only on the 16th.
- Throughput: one frame per 16 cycles when `GAP`=0, and one per 16+`GAP`+1 cycles otherwise (the extra cycle is the IDLE acceptance cycle).
- Reset asserted mid-frame: outputs return to reset values immediately. The frame is lost and no `frame_last` is produced.
- The downstream mux is combinational, so `f` is valid in the same cycle as `s`. The consumer samples `f` at the edge ending each `bit_valid` cycle.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, release → `w`=0, `s`=0, `bit_valid`=0, `busy`=0, `load_ready`=1.
- **LSB-first frame:** `MSB_FIRST`=0, `GAP`=0; load 16'hA5C3 once → `s` reads 0..15 over 16 cycles, sampled `f` sequence = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; `frame_last` only at `s`=15; then IDLE.
- **MSB-first back-to-back:** `MSB_FIRST`=1, `GAP`=0; hold `load_valid` with 16'hFFFF then 16'h0001 → 32 consecutive `bit_valid` cycles, no bubble; `s` goes 15→0 twice; second frame emits fifteen 0s then a 1.
- **Gap spacing:** `GAP`=3; two words queued → after `frame_last`, `bit_valid` is low for 3 GAP cycles plus 1 IDLE cycle; the next frame starts 5 cycles after `frame_last`.
- **Abort:** assert `abort` at the edge where `s`=6 → next cycle IDLE, `bit_valid`=0, `s` holds 6, no `frame_last`. Abort coincident with a final-bit reload → load not accepted, `load_ready`=0 that cycle.
- **Async reset mid-frame:** drop `rst_n` between edges while `s`=9 → outputs go to reset values immediately, before the next edge; a new load after release starts at `s`=`START`.
